// File: rtl/ctrlbus_pkg.sv
// Shared types and bit-position constants for the CTRL bus command master.
`timescale 1ns/1ps
package ctrlbus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RISE,
    WAIT_FALL,
    RESPOND
  } state_t;

  // Command word layout
  localparam int CMD_WR_BIT   = 31;
  localparam int CMD_ADDR_LSB = 16;
  localparam int CMD_DATA_LSB = 0;

  // Response word layout
  localparam int RSP_ERR_BIT  = 31;
  localparam int RSP_WR_BIT   = 30;
  localparam int RSP_ADDR_LSB = 16;
  localparam int RSP_DATA_LSB = 0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [31:0] pack_rsp(input logic err, input logic wr,
                                           input logic [7:0] addr,
                                           input logic [15:0] data);
    logic [31:0] w;
    w = '0;
    w[RSP_ERR_BIT] = err;
    w[RSP_WR_BIT]  = wr;
    w[RSP_ADDR_LSB +: 8]  = addr;
    w[RSP_DATA_LSB +: 16] = data;
    return w;
  endfunction

endpackage

// File: rtl/ctrlbus_cmd_master.sv
// Executes one CTRL bus transaction per host command word and returns one response word.
// Optional busy-stuck timeout is enabled by defining CTRLBUS_CMD_TIMEOUT_EN.
`timescale 1ns/1ps
module ctrlbus_cmd_master
  import ctrlbus_pkg::*;
#(
  parameter int g_WidthADDR     = 8,
  parameter int g_WidthDATA     = 16,
  parameter int g_RiseWindow    = 4,
  parameter int g_TimeoutCycles = 4096
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [31:0]            Cmd_Data,
  input  logic                   Cmd_Valid,
  output logic                   Cmd_Ready,
  output logic [31:0]            Rsp_Data,
  output logic                   Rsp_Valid,
  input  logic                   Rsp_Ready,
  output logic                   CTRL_enable_cmd,
  output logic                   CTRL_write_read,
  output logic [g_WidthADDR-1:0] CTRL_addr_frame,
  output logic [g_WidthDATA-1:0] CTRL_write_data_frame,
  input  logic [g_WidthDATA-1:0] CTRL_read_data_frame,
  input  logic                   CTRL_busy
);

  localparam int CNT_MAX = max_int(g_RiseWindow, g_TimeoutCycles);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(g_RiseWindow - 1);
`ifdef CTRLBUS_CMD_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(g_TimeoutCycles - 1);
`endif

  state_t                 state_reg;
  logic                   cmd_ready_reg;
  logic                   rsp_valid_reg;
  logic [31:0]            rsp_data_reg;
  logic                   enable_reg;
  logic                   write_read_reg;
  logic [g_WidthADDR-1:0] addr_reg;
  logic [g_WidthDATA-1:0] wdata_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [CNT_W-1:0]       cnt_inc;
  logic [15:0]            rd_capture;

  // Opcode-reserved command bits carry no meaning here.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^Cmd_Data[30:24];

  assign cnt_inc    = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;
  assign rd_capture = write_read_reg ? 16'h0000 : 16'(CTRL_read_data_frame);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg      <= IDLE;
      cmd_ready_reg  <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_data_reg   <= '0;
      enable_reg     <= 1'b0;
      write_read_reg <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      cnt_reg        <= '0;
    end else begin
      enable_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_ready_reg && Cmd_Valid) begin
            cmd_ready_reg  <= 1'b0;
            write_read_reg <= Cmd_Data[CMD_WR_BIT];
            addr_reg       <= Cmd_Data[CMD_ADDR_LSB +: g_WidthADDR];
            wdata_reg      <= Cmd_Data[CMD_DATA_LSB +: g_WidthDATA];
            enable_reg     <= 1'b1;
            state_reg      <= ISSUE;
          end else begin
            cmd_ready_reg <= 1'b1;
          end
        end

        ISSUE: begin
          cnt_reg   <= '0;
          state_reg <= WAIT_RISE;
        end

        WAIT_RISE: begin
          if (CTRL_busy) begin
            cnt_reg   <= '0;
            state_reg <= WAIT_FALL;
          end else if (cnt_reg == RISE_LAST) begin
            // Peripheral never went busy: treat as a zero-wait completion.
            rsp_valid_reg <= 1'b1;
            rsp_data_reg  <= pack_rsp(1'b0, write_read_reg, 8'(addr_reg), rd_capture);
            state_reg     <= RESPOND;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end

        WAIT_FALL: begin
          if (!CTRL_busy) begin
            rsp_valid_reg <= 1'b1;
            rsp_data_reg  <= pack_rsp(1'b0, write_read_reg, 8'(addr_reg), rd_capture);
            state_reg     <= RESPOND;
          end
`ifdef CTRLBUS_CMD_TIMEOUT_EN
          else if (cnt_reg == TIMEOUT_LAST) begin
            rsp_valid_reg <= 1'b1;
            rsp_data_reg  <= pack_rsp(1'b1, write_read_reg, 8'(addr_reg), 16'h0000);
            state_reg     <= RESPOND;
          end else begin
            cnt_reg <= cnt_inc;
          end
`endif
        end

        RESPOND: begin
          if (Rsp_Ready) begin
            rsp_valid_reg <= 1'b0;
            cmd_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign Cmd_Ready             = cmd_ready_reg;
  assign Rsp_Valid             = rsp_valid_reg;
  assign Rsp_Data              = rsp_data_reg;
  assign CTRL_enable_cmd       = enable_reg;
  assign CTRL_write_read       = write_read_reg;
  assign CTRL_addr_frame       = addr_reg;
  assign CTRL_write_data_frame = wdata_reg;

endmodule

// File: tb/tb_ctrlbus_cmd_master.sv
// Randomized self-checking bench for ctrlbus_cmd_master against a cycle-arithmetic reference model.
`timescale 1ns/1ps
module tb_ctrlbus_cmd_master;

  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] rsp_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        ctrl_enable_cmd;
  logic        ctrl_write_read;
  logic [7:0]  ctrl_addr_frame;
  logic [15:0] ctrl_write_data_frame;
  logic [15:0] ctrl_read_data_frame;
  logic        ctrl_busy;

  int errors = 0;
  int checks = 0;
  int txn    = 0;

  always #5 clock = ~clock;

  ctrlbus_cmd_master #(
    .g_WidthADDR(8), .g_WidthDATA(16), .g_RiseWindow(4), .g_TimeoutCycles(TO)
  ) dut (
    .Clock(clock), .Reset(reset),
    .Cmd_Data(cmd_data), .Cmd_Valid(cmd_valid), .Cmd_Ready(cmd_ready),
    .Rsp_Data(rsp_data), .Rsp_Valid(rsp_valid), .Rsp_Ready(rsp_ready),
    .CTRL_enable_cmd(ctrl_enable_cmd), .CTRL_write_read(ctrl_write_read),
    .CTRL_addr_frame(ctrl_addr_frame), .CTRL_write_data_frame(ctrl_write_data_frame),
    .CTRL_read_data_frame(ctrl_read_data_frame), .CTRL_busy(ctrl_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    check({tag, "_rsp_data"}, rsp_data, 32'h0);
    check({tag, "_enable"}, 32'(ctrl_enable_cmd), 32'h0);
    check({tag, "_write_read"}, 32'(ctrl_write_read), 32'h0);
    check({tag, "_addr"}, 32'(ctrl_addr_frame), 32'h0);
    check({tag, "_wdata"}, 32'(ctrl_write_data_frame), 32'h0);
  endtask

  // Cycle 0 is the handshake cycle, cycle 1 carries the enable strobe.
  // Peripheral busy is high in cycles r+1 .. r+d (d=0: never busy).
  task automatic run_cmd(input logic [31:0] cmd, input int r, input int d,
                         input logic [15:0] rd, input int hold);
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        err;
    logic        seen;
    logic [31:0] exp_rsp;
    int rc, sc, w, f, ra, busy_end, kmax, enables, waited;
    wr    = cmd[31];
    addr  = cmd[23:16];
    wdata = cmd[15:0];
    err   = 1'b0;
    seen  = (d > 0) && ((r >= 1 && r <= 4) || (r == 0 && d >= 2));
    if (!seen) begin
      rc = 6;
      sc = 5;
    end else begin
      w = 2 + ((r > 1) ? r : 1);
      f = 1 + r + d;
      rc = f + 1;
      sc = f;
`ifdef CTRLBUS_CMD_TIMEOUT_EN
      if (f > w + TO - 1) begin
        rc  = w + TO;
        sc  = -1;
        err = 1'b1;
      end
`endif
    end
    exp_rsp  = {err, wr, 6'b0, addr, (wr || err) ? 16'h0000 : rd};
    ra       = rc + hold;
    busy_end = (d > 0) ? r + d : 0;
    kmax     = (ra + 1 > busy_end + 1) ? ra + 1 : busy_end + 1;

    waited = 0;
    while (!cmd_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_wait", 32'(cmd_ready), 32'h1);
      return;
    end

    cmd_valid            = 1'b1;
    cmd_data             = cmd;
    ctrl_busy            = ($urandom_range(0, 1) == 1);
    rsp_ready            = ($urandom_range(0, 1) == 1);
    ctrl_read_data_frame = 16'($urandom);
    enables = 0;
    for (int k = 1; k <= kmax; k++) begin
      @(negedge clock);
      enables += int'(ctrl_enable_cmd);
      if (k == 1) check("enable_pulse", 32'(ctrl_enable_cmd), 32'h1);
      if (k <= ra) begin
        check("write_read", 32'(ctrl_write_read), 32'(wr));
        check("addr_frame", 32'(ctrl_addr_frame), 32'(addr));
        check("wdata_frame", 32'(ctrl_write_data_frame), 32'(wdata));
      end
      check("rsp_valid", 32'(rsp_valid), 32'((k >= rc) && (k <= ra)));
      if (k >= rc && k <= ra) check("rsp_data", rsp_data, exp_rsp);
      check("cmd_ready", 32'(cmd_ready), 32'(k > ra));

      cmd_valid            = (k < ra);
      cmd_data             = (k < ra) ? $urandom : 32'h0;
      ctrl_busy            = (k >= r + 1) && (k <= r + d);
      ctrl_read_data_frame = (k == sc) ? rd : 16'($urandom);
      rsp_ready            = (k == ra) ? 1'b1 : ((k < rc) ? ($urandom_range(0, 1) == 1) : 1'b0);
    end
    check("enable_count", 32'(enables), 32'h1);
    cmd_valid = 1'b0;
    ctrl_busy = 1'b0;
    rsp_ready = 1'b0;
    txn++;
    $display("txn %0d cmd=%h rise=%0d busy=%0d hold=%0d expect_rsp=%h", txn, cmd, r, d, hold, exp_rsp);
  endtask

  task automatic reset_mid_wait_fall();
    cmd_data  = 32'h80AB1234;
    cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    ctrl_busy = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      cmd_valid = 1'b0;
      ctrl_busy = (k >= 2);
    end
    check("pre_reset_addr", 32'(ctrl_addr_frame), 32'h000000AB);
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    @(negedge clock);
    reset = 1'b0;
    check("release_cmd_ready", 32'(cmd_ready), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      check("post_reset_cmd_ready", 32'(cmd_ready), 32'h1);
      check("post_reset_rsp_valid", 32'(rsp_valid), 32'h0);
    end
    ctrl_busy = 1'b0;
    $display("txn reset during WAIT_FALL: response discarded");
  endtask

  initial begin
    reset                = 1'b1;
    cmd_data             = '0;
    cmd_valid            = 1'b0;
    rsp_ready            = 1'b0;
    ctrl_read_data_frame = '0;
    ctrl_busy            = 1'b0;
    repeat (2) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;
    check("release_cmd_ready", 32'(cmd_ready), 32'h0);
    @(negedge clock);
    check("first_cmd_ready", 32'(cmd_ready), 32'h1);

    run_cmd(32'h8012ABCD, 1, 5, 16'h1111, 0);   // write, busy 5 cycles
    run_cmd(32'h00340000, 1, 3, 16'h5A5A, 1);   // read, busy 3 cycles
    run_cmd(32'h00560000, 0, 0, 16'hC3C3, 0);   // busy never rises
    run_cmd(32'h00770000, 2, 2, 16'h0F0F, 10);  // response stalled
    run_cmd(32'h00890000, 0, 4, 16'h2468, 2);   // busy already high at issue
    run_cmd(32'h009A0000, 4, 1, 16'h1357, 0);   // busy rises at last window cycle
    reset_mid_wait_fall();
`ifdef CTRLBUS_CMD_TIMEOUT_EN
    run_cmd(32'h00AA0000, 1, 40, 16'hBEEF, 0);  // busy stuck: timeout
    run_cmd(32'h00BB0000, 1, TO, 16'hCAFE, 0);  // falls on the timeout cycle
    run_cmd(32'h80CC5555, 1, TO + 1, 16'hDEAD, 1);
`else
    run_cmd(32'h00AA0000, 1, 40, 16'hBEEF, 0);  // long busy, no timeout
`endif
    for (int i = 0; i < 40; i++) begin
      run_cmd($urandom, $urandom_range(0, 6), $urandom_range(0, 8),
              16'($urandom), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
